// File: rtl/wb_regfile_if.sv
// Write-back / register-file bus: MEM/WB inputs, decode read ports, status.
// Master drives the pipeline side; slave is the regfile.
interface wb_regfile_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [1:0]        wb;
  logic [DATA_W-1:0] read_data;
  logic [DATA_W-1:0] alu_result;
  logic [ADDR_W-1:0] write_reg;
  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic [DATA_W-1:0] wb_data;
  logic [31:0]       wr_count;

  modport master (
    output wb, read_data, alu_result, write_reg,
    output rs_addr, rt_addr,
    input  rs_data, rt_data, wb_data, wr_count
  );

  modport slave (
    input  wb, read_data, alu_result, write_reg,
    input  rs_addr, rt_addr,
    output rs_data, rt_data, wb_data, wr_count
  );
endinterface

// File: rtl/wb_regfile.sv
// Write-back mux plus 32-entry register file with two bypassed read ports.
// Register 0 is hardwired to zero.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input logic         clk,
  input logic         rst_n,
  wb_regfile_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DATA_W-1:0] wb_data;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic [31:0]       wr_count;
  logic              write_en;

  assign wb_data  = bus.wb[0] ? bus.read_data : bus.alu_result;
  // rst_n gates commit and bypass together
  assign write_en = bus.wb[1] & (|bus.write_reg) & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      wr_count <= '0;
    end else if (write_en) begin
      regs[bus.write_reg] <= wb_data;
      wr_count            <= wr_count + 32'd1;
    end
  end

  always_comb begin
    rs_data = '0;
    unique case (1'b1)
      (bus.rs_addr == '0): rs_data = '0;
      (write_en && bus.rs_addr == bus.write_reg):
        rs_data = wb_data;
      default: rs_data = regs[bus.rs_addr];
    endcase
  end

  always_comb begin
    rt_data = '0;
    unique case (1'b1)
      (bus.rt_addr == '0): rt_data = '0;
      (write_en && bus.rt_addr == bus.write_reg):
        rt_data = wb_data;
      default: rt_data = regs[bus.rt_addr];
    endcase
  end

  assign bus.wb_data  = wb_data;
  assign bus.rs_data  = rs_data;
  assign bus.rt_data  = rt_data;
  assign bus.wr_count = wr_count;
endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back stage plus architectural register file, directly downstream of the MEM/WB pipeline buffer.
- Consumes the buffered write-back control, memory load data, ALU result and destination register number.
- Selects the write-back value, commits it to a 32-entry register file on the rising clock edge, and serves two combinational read ports to decode.
- Read ports include same-cycle write-through bypass, so decode never reads a stale value from the instruction currently in write-back.

Parameters:
- DATA_W, 32, width of each register and of all data ports.
- ADDR_W, 5, register index width; depth is 2**ADDR_W (32 entries).

Ports:
- clk  input  1  rising-edge clock shared with all pipeline buffers.
- rst_n  input  1  asynchronous, active-low reset.
- wb  input  2  write-back control from MEM/WB: bit1 = RegWrite, bit0 = MemToReg.
- read_data  input  DATA_W  load data from MEM/WB.
- alu_result  input  DATA_W  ALU result from MEM/WB.
- write_reg  input  ADDR_W  destination register index from MEM/WB.
- rs_addr  input  ADDR_W  read port A index (decode stage).
- rt_addr  input  ADDR_W  read port B index (decode stage).
- rs_data  output  DATA_W  read port A data, combinational.
- rt_data  output  DATA_W  read port B data, combinational.
- wb_data  output  DATA_W  selected write-back value, combinational.
- wr_count  output  32  number of committed register writes since reset.

Behaviour:
- Clocking: one clock, clk. Reset is asynchronous and active-low on rst_n. While rst_n = 0, all state is held at reset values regardless of clk.
- Reset values:
  - All 32 registers = 0.
  - wr_count = 0.
  - rs_data, rt_data and wb_data follow the combinational rules below.
  - Bypass is disabled while rst_n = 0, so rs_data and rt_data read 0.
- Write-back mux: wb_data = read_data when wb[0] = 1, else alu_result. Zero latency; purely combinational.
- Commit: write_en = wb[1] AND (write_reg != 0) AND rst_n.
  - On posedge clk with write_en = 1, reg[write_reg] <= wb_data.
  - Exactly one register is written per cycle.
  - Latency is 1 clock: the value is architecturally visible from the next cycle.
- Register 0:
  - Hardwired to 0. Writes with write_reg = 0 are discarded and do not increment wr_count.
  - Reads of index 0 always return 0, including under bypass.
- Read ports:
  - rs_data = 0 if rs_addr = 0.
  - Else rs_data = wb_data if write_en = 1 and rs_addr = write_reg.
  - Else rs_data = reg[rs_addr].
  - rt_data follows the identical rule using rt_addr.
  - Both ports may address the same register; both return the same value.
- wr_count:
  - Increments by 1 on each posedge clk where write_en = 1.
  - Wraps from 32'hFFFFFFFF to 0 with no flag.
- Simultaneous events:
  - Bypass and commit in the same cycle: the read sees the new value in that cycle, and the register holds it from the next cycle.
  - wb[1] = 0 with a nonzero write_reg: no write, no bypass, no count.
- Reset mid-operation:
  - Assertion of rst_n clears all registers and wr_count immediately, without waiting for clk.
  - A write pending in the same cycle as the assertion is lost.
  - The first write after deassertion occurs on the first posedge clk where rst_n = 1 and write_en = 1.
- X-handling: with wb[1] = 0, the values of read_data, alu_result and write_reg must not affect any state.

Test Plan:
- Reset check: hold rst_n = 0 for 3 cycles, then release. Read all 32 indices on rs_addr/rt_addr -> every read = 0 and wr_count = 0.
- ALU write-back: wb = 2'b10, alu_result = 32'h0000_1234, read_data = 32'hDEAD_BEEF, write_reg = 5.
  - wb_data = 32'h0000_1234.
  - Next cycle, with wb = 0 and rs_addr = 5, rs_data = 32'h0000_1234.
  - wr_count = 1.
- Load write-back with bypass: wb = 2'b11, read_data = 32'hCAFE_F00D, write_reg = 9, rs_addr = rt_addr = 9 in the same cycle.
  - rs_data = rt_data = 32'hCAFE_F00D before the clock edge.
  - After the edge, with wb = 0, both still read 32'hCAFE_F00D.
- Register 0 protection: wb = 2'b10, alu_result = 32'hFFFF_FFFF, write_reg = 0, rs_addr = 0.
  - rs_data = 0 during and after the cycle.
  - wr_count is unchanged.
- Write disabled: wb = 2'b01, write_reg = 7, read_data = 32'h1111_1111.
  - reg 7 keeps its prior value (0 after reset).
  - No bypass on rs_addr = 7.
  - wr_count is unchanged.
- Async reset mid-stream: commit writes to regs 1–4, then pull rst_n low between clock edges.
  - rs_data for 1–4 = 0 immediately, without waiting for a clock edge.
  - wr_count = 0.
  - A write presented while rst_n = 0 is not committed.
